fpu_thread_demux_pipe: RTL and testbench
========================================

// Module: fpu_thread_demux_pipe
// PURPOSE
//  Parametrised N-thread successor to the 2-thread FPU demux. Tracks the owning thread
//  of every FP op through the E1/E2/E3/W stages and owns an iterative div/sqrt unit.
//  Routes write enables, the div/sqrt stall and the div/sqrt completion to per-thread
//  one-hot lines. Sits between the multithreaded decode stage and per-thread FP regfiles.
// PARAMETERS
//  NT       4  number of hardware threads (2..16)
//  TW       2  thread-id width; ceil(log2(NT)), minimum 1
//  DIV_LAT  8  div/sqrt busy cycles from accept to done (2..64)
// PORTS
//  clk        in   1      clock, rising edge
//  clr        in   1      asynchronous reset, active-high
//  dt         in   TW     thread id of the op in D
//  d_fwe      in   1      D op is a pipelined FP op writing the FP regfile
//  d_fdiv     in   1      D op is a div/sqrt
//  ext_stall  in   1      stall of D from elsewhere; D op not issued this cycle
//  e1t,e2t,e3t,wt  out TW each  thread tag of each stage (registered)
//  e1w,e2w,e3w,ww  out 1 each   stage holds a valid writing op (registered)
//  e1w_oh,e2w_oh,e3w_oh,ww_oh out NT each  per-thread one-hot of stage valid
//  stall_div_sqrt     out 1   D div/sqrt blocked by busy unit (combinational)
//  stall_div_sqrt_oh  out NT  onehot(dt) & stall_div_sqrt
//  div_busy   out 1   div/sqrt unit occupied
//  div_t      out TW  owner thread of current/last div/sqrt
//  div_done   out 1   one-cycle pulse, result ready for div_t
//  div_done_oh out NT onehot(div_t) & div_done
// BEHAVIOUR
//  Reset: all stage valids 0, tags 0, div_busy 0, counter 0, div_t 0, div_done 0;
//   all *_oh outputs 0. Reset mid-div aborts it with no div_done pulse.
//  Tag valid: dt < NT. An op with dt >= NT is never issued (bubble, no stall, no oh).
//  Issue: iss = d_fwe & ~d_fdiv & ~ext_stall & (dt<NT). Ops with both d_fwe and d_fdiv
//   set are treated as div/sqrt.
//  Pipe: free-running, never stalls. Each clk: E1<={iss,dt}; E2<=E1; E3<=E2; W<=E3.
//   ext_stall only injects a bubble into E1. A written op reaches ww exactly 4 cycles
//   after its issue cycle. Invalid stages keep their tag; only the valid bit clears.
//  Div FSM: IDLE, BUSY.
//   IDLE: d_fdiv & ~ext_stall & (dt<NT) -> BUSY, div_t<=dt, cnt<=DIV_LAT-1.
//   BUSY: cnt decrements each cycle. When cnt==0: div_done=1 for that cycle, -> IDLE
//    on the next edge. Total: div_busy high DIV_LAT cycles after the accept edge.
//  Stall: stall_div_sqrt = d_fdiv & (dt<NT) & div_busy & ~(cnt==0).
//   In the done cycle, a new div from any thread is accepted (back-to-back, no bubble):
//   div_done pulses and BUSY reloads on the same edge with the new owner.
//   ext_stall does not gate stall_div_sqrt. A stalled div is not accepted.
//  One-hot rule: every *_oh[i] = valid & (tag==i); at most one bit set per vector.
//  div_done and ww for the same thread in one cycle are both reported. Write-port
//   arbitration belongs to the regfile.
// TESTING
//  T1 reset: assert clr mid-div (cnt=3) -> all outputs 0 at once, no later div_done.
//  T2 pipe: NT=4, issue dt=2 with d_fwe at cycle 0 -> e1w_oh=0100 c1, e2w c2, e3w c3,
//     ww_oh=0100 c4; ext_stall at issue -> no valid anywhere.
//  T3 interleave: dt=0,1,2,3 on consecutive cycles -> ww_oh 0001,0010,0100,1000 on
//     cycles 4..7.
//  T4 div: DIV_LAT=8, div dt=1 at c0 -> div_busy c1..c8, div_done_oh=0010 at c8.
//     Div dt=3 at c4 -> stall_div_sqrt_oh=1000.
//  T5 back-to-back: div dt=3 held at c8 (done cycle) -> accepted, no stall,
//     div_t=3, div_done at c16.
//  T6 bad tag: NT=3, dt=3 with d_fwe/d_fdiv -> no valid, no stall, div_busy stays 0.

Source files
------------

// File: rtl/fpu_thread_demux_pipe.sv
// fpu_thread_demux_pipe: N-thread FP op tracker for E1/E2/E3/W and owner of
// an iterative div/sqrt unit; routes per-thread write/stall/done one-hots.
// Ports: clk, clr (async, active-high); dt/d_fwe/d_fdiv/ext_stall from D;
// e1t..wt/e1w..ww stage tags+valids and their *_oh per-thread vectors;
// stall_div_sqrt(_oh), div_busy, div_t, div_done(_oh) for the div/sqrt unit.
module fpu_thread_demux_pipe #(
  parameter int NT      = 4,
  parameter int TW      = 2,
  parameter int DIV_LAT = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [TW-1:0] dt,
  input  logic          d_fwe,
  input  logic          d_fdiv,
  input  logic          ext_stall,
  output logic [TW-1:0] e1t,
  output logic [TW-1:0] e2t,
  output logic [TW-1:0] e3t,
  output logic [TW-1:0] wt,
  output logic          e1w,
  output logic          e2w,
  output logic          e3w,
  output logic          ww,
  output logic [NT-1:0] e1w_oh,
  output logic [NT-1:0] e2w_oh,
  output logic [NT-1:0] e3w_oh,
  output logic [NT-1:0] ww_oh,
  output logic          stall_div_sqrt,
  output logic [NT-1:0] stall_div_sqrt_oh,
  output logic          div_busy,
  output logic [TW-1:0] div_t,
  output logic          div_done,
  output logic [NT-1:0] div_done_oh
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] div_t_q, div_t_d;

  logic          e1w_q, e2w_q, e3w_q, ww_q;
  logic          e1w_d, e2w_d, e3w_d, ww_d;
  logic [TW-1:0] e1t_q, e2t_q, e3t_q, wt_q;
  logic [TW-1:0] e1t_d, e2t_d, e3t_d, wt_d;

  logic tag_ok;
  logic iss;
  logic cnt_zero;
  logic busy;
  logic div_acc;

  assign tag_ok   = ({{(32-TW){1'b0}}, dt} < NT[31:0]);
  // div/sqrt wins when both flags are set
  assign iss      = d_fwe & ~d_fdiv & ~ext_stall & tag_ok;
  assign busy     = (st_q == BUSY);
  assign cnt_zero = (cnt_q == '0);
  // done cycle frees the unit for a same-edge reload
  assign div_acc  = d_fdiv & ~ext_stall & tag_ok
                  & (~busy | cnt_zero);

  assign stall_div_sqrt = d_fdiv & tag_ok & busy & ~cnt_zero;
  assign div_done       = busy & cnt_zero;
  assign div_busy       = busy;
  assign div_t          = div_t_q;

  assign e1w = e1w_q;
  assign e2w = e2w_q;
  assign e3w = e3w_q;
  assign ww  = ww_q;
  assign e1t = e1t_q;
  assign e2t = e2t_q;
  assign e3t = e3t_q;
  assign wt  = wt_q;

  always_comb begin
    e1w_d = iss;
    e1t_d = dt;
    e2w_d = e1w_q;
    e2t_d = e1t_q;
    e3w_d = e2w_q;
    e3t_d = e2t_q;
    ww_d  = e3w_q;
    wt_d  = e3t_q;
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    div_t_d = div_t_q;
    unique case (st_q)
      IDLE: begin
        if (div_acc) begin
          st_d    = BUSY;
          cnt_d   = CW'(DIV_LAT - 1);
          div_t_d = dt;
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          if (div_acc) begin
            cnt_d   = CW'(DIV_LAT - 1);
            div_t_d = dt;
          end else begin
            st_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    e1w_oh            = '0;
    e2w_oh            = '0;
    e3w_oh            = '0;
    ww_oh             = '0;
    stall_div_sqrt_oh = '0;
    div_done_oh       = '0;
    for (int i = 0; i < NT; i++) begin
      e1w_oh[i] = e1w_q & (e1t_q == i[TW-1:0]);
      e2w_oh[i] = e2w_q & (e2t_q == i[TW-1:0]);
      e3w_oh[i] = e3w_q & (e3t_q == i[TW-1:0]);
      ww_oh[i]  = ww_q  & (wt_q  == i[TW-1:0]);
      stall_div_sqrt_oh[i] = stall_div_sqrt
                           & (dt == i[TW-1:0]);
      div_done_oh[i] = div_done
                     & (div_t_q == i[TW-1:0]);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      e1w_q   <= 1'b0;
      e2w_q   <= 1'b0;
      e3w_q   <= 1'b0;
      ww_q    <= 1'b0;
      e1t_q   <= '0;
      e2t_q   <= '0;
      e3t_q   <= '0;
      wt_q    <= '0;
      st_q    <= IDLE;
      cnt_q   <= '0;
      div_t_q <= '0;
    end else begin
      e1w_q   <= e1w_d;
      e2w_q   <= e2w_d;
      e3w_q   <= e3w_d;
      ww_q    <= ww_d;
      e1t_q   <= e1t_d;
      e2t_q   <= e2t_d;
      e3t_q   <= e3t_d;
      wt_q    <= wt_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      div_t_q <= div_t_d;
    end
  end

endmodule

// File: tb/tb_fpu_thread_demux_pipe.sv
// tb_fpu_thread_demux_pipe: scoreboard bench for fpu_thread_demux_pipe.
// Instance a uses NT=4, instance b uses NT=3 for the bad-tag case.
module tb_fpu_thread_demux_pipe;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] dt;
  logic       d_fwe, d_fdiv, ext_stall;

  logic [1:0] a_e1t, a_e2t, a_e3t, a_wt, a_div_t;
  logic       a_e1w, a_e2w, a_e3w, a_ww;
  logic [3:0] a_e1w_oh, a_e2w_oh, a_e3w_oh, a_ww_oh;
  logic       a_stall, a_busy, a_done;
  logic [3:0] a_stall_oh, a_done_oh;

  logic [1:0] b_e1t, b_e2t, b_e3t, b_wt, b_div_t;
  logic       b_e1w, b_e2w, b_e3w, b_ww;
  logic [2:0] b_e1w_oh, b_e2w_oh, b_e3w_oh, b_ww_oh;
  logic       b_stall, b_busy, b_done;
  logic [2:0] b_stall_oh, b_done_oh;

  typedef struct {
    int         due;
    logic [3:0] oh;
  } exp_t;

  exp_t ww_q[$];
  exp_t done_q[$];

  int cyc;
  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  fpu_thread_demux_pipe #(.NT(4), .TW(2), .DIV_LAT(8)) u_a (
    .clk(clk), .clr(clr), .dt(dt), .d_fwe(d_fwe),
    .d_fdiv(d_fdiv), .ext_stall(ext_stall),
    .e1t(a_e1t), .e2t(a_e2t), .e3t(a_e3t), .wt(a_wt),
    .e1w(a_e1w), .e2w(a_e2w), .e3w(a_e3w), .ww(a_ww),
    .e1w_oh(a_e1w_oh), .e2w_oh(a_e2w_oh),
    .e3w_oh(a_e3w_oh), .ww_oh(a_ww_oh),
    .stall_div_sqrt(a_stall), .stall_div_sqrt_oh(a_stall_oh),
    .div_busy(a_busy), .div_t(a_div_t),
    .div_done(a_done), .div_done_oh(a_done_oh)
  );

  fpu_thread_demux_pipe #(.NT(3), .TW(2), .DIV_LAT(8)) u_b (
    .clk(clk), .clr(clr), .dt(dt), .d_fwe(d_fwe),
    .d_fdiv(d_fdiv), .ext_stall(ext_stall),
    .e1t(b_e1t), .e2t(b_e2t), .e3t(b_e3t), .wt(b_wt),
    .e1w(b_e1w), .e2w(b_e2w), .e3w(b_e3w), .ww(b_ww),
    .e1w_oh(b_e1w_oh), .e2w_oh(b_e2w_oh),
    .e3w_oh(b_e3w_oh), .ww_oh(b_ww_oh),
    .stall_div_sqrt(b_stall), .stall_div_sqrt_oh(b_stall_oh),
    .div_busy(b_busy), .div_t(b_div_t),
    .div_done(b_done), .div_done_oh(b_done_oh)
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    dt        = 2'd0;
    d_fwe     = 1'b0;
    d_fdiv    = 1'b0;
    ext_stall = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    clr = 1'b1;
    idle_in();
    #1;
    n_chk++;
    if ({a_e1w, a_e2w, a_e3w, a_ww, a_busy, a_done,
         a_div_t, a_ww_oh, a_done_oh} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got %b expected 0",
        {a_e1w, a_e2w, a_e3w, a_ww, a_busy, a_done,
         a_div_t, a_ww_oh, a_done_oh});
    end
    @(negedge clk);
    clr = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      idle_in();
      if (k == 0) begin
        d_fdiv = 1'b1;
        dt     = 2'd2;
      end
      if (k >= 1 && k <= 3) begin
        d_fwe = 1'b1;
        dt    = 2'd1;
      end
      if (k == 5) begin
        #2;
        clr = 1'b1;
      end
      #1;
      if (k == 5) begin
        n_chk++;
        if ({a_e1w, a_e2w, a_e3w, a_ww, a_busy, a_done,
             a_div_t, a_e1w_oh, a_e2w_oh, a_e3w_oh,
             a_ww_oh, a_done_oh, a_stall} !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_div: got busy=%b done=%b e3w=%b ww=%b expected all 0",
            a_busy, a_done, a_e3w, a_ww);
        end
      end else if (k == 4) begin
        n_chk++;
        exp = 4'b0010;
        if (a_busy !== 1'b1 || a_e3w_oh !== exp) begin
          n_fail++;
          $display("FAIL pre_reset: busy=%b e3w_oh=%b expected 1/%b",
            a_busy, a_e3w_oh, exp);
        end
      end
      if (k < 5) tick();
    end
    tick();
    clr = 1'b0;
    idle_in();
    for (int k = 0; k < 12; k++) begin
      #1;
      n_chk++;
      if (a_done !== 1'b0 || a_busy !== 1'b0 || a_ww !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: done=%b busy=%b ww=%b expected 0",
          a_done, a_busy, a_ww);
      end
      tick();
    end
  endtask

  task automatic test_pipe();
    logic [3:0] exp;
    ww_q.delete();
    for (int k = 0; k < 7; k++) begin
      idle_in();
      if (k == 0) begin
        dt    = 2'd2;
        d_fwe = 1'b1;
        ww_q.push_back('{cyc + 4, 4'b0100});
      end
      #1;
      if (k == 1) begin
        n_chk++;
        if (a_e1w_oh !== 4'b0100 || a_e1t !== 2'd2) begin
          n_fail++;
          $display("FAIL pipe_e1: oh=%b t=%0d expected 0100/2", a_e1w_oh, a_e1t);
        end
      end
      if (k == 2) begin
        n_chk++;
        if (a_e2w_oh !== 4'b0100 || a_e1w !== 1'b0) begin
          n_fail++;
          $display("FAIL pipe_e2: oh=%b e1w=%b expected 0100/0", a_e2w_oh, a_e1w);
        end
      end
      if (k == 3) begin
        n_chk++;
        if (a_e3w_oh !== 4'b0100 || a_e3t !== 2'd2) begin
          n_fail++;
          $display("FAIL pipe_e3: oh=%b t=%0d expected 0100/2", a_e3w_oh, a_e3t);
        end
      end
      exp = 4'b0000;
      if (ww_q.size() > 0 && ww_q[0].due == cyc) exp = ww_q.pop_front().oh;
      n_chk++;
      if (a_ww_oh !== exp || a_ww !== (|exp)) begin
        n_fail++;
        $display("FAIL pipe_ww c%0d: oh=%b ww=%b expected %b", k, a_ww_oh, a_ww, exp);
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      idle_in();
      if (k == 0) begin
        dt        = 2'd2;
        d_fwe     = 1'b1;
        ext_stall = 1'b1;
      end
      #1;
      if (k >= 1) begin
        n_chk++;
        if ({a_e1w, a_e2w, a_e3w, a_ww, a_ww_oh} !== '0) begin
          n_fail++;
          $display("FAIL pipe_ext_stall c%0d: valids=%b expected 0",
            k, {a_e1w, a_e2w, a_e3w, a_ww});
        end
      end
      tick();
    end
  endtask

  task automatic test_interleave();
    logic [3:0] exp;
    ww_q.delete();
    for (int k = 0; k < 10; k++) begin
      idle_in();
      if (k < 4) begin
        dt    = k[1:0];
        d_fwe = 1'b1;
        ww_q.push_back('{cyc + 4, 4'b0001 << k});
      end
      #1;
      exp = 4'b0000;
      if (ww_q.size() > 0 && ww_q[0].due == cyc) exp = ww_q.pop_front().oh;
      n_chk++;
      if (a_ww_oh !== exp || a_ww !== (|exp)) begin
        n_fail++;
        $display("FAIL interleave_ww c%0d: oh=%b expected %b", k, a_ww_oh, exp);
      end
      tick();
    end
    n_chk++;
    if (ww_q.size() != 0) begin
      n_fail++;
      $display("FAIL interleave_drain: %0d pending expected 0", ww_q.size());
    end
  endtask

  task automatic test_div();
    logic [3:0] exp;
    done_q.delete();
    for (int k = 0; k < 8; k++) begin
      idle_in();
      if (k == 0) begin
        dt     = 2'd1;
        d_fdiv = 1'b1;
        done_q.push_back('{cyc + 8, 4'b0010});
      end
      if (k == 4) begin
        dt     = 2'd3;
        d_fdiv = 1'b1;
      end
      #1;
      if (k >= 1) begin
        n_chk++;
        if (a_busy !== 1'b1 || a_div_t !== 2'd1) begin
          n_fail++;
          $display("FAIL div_busy c%0d: busy=%b t=%0d expected 1/1", k, a_busy, a_div_t);
        end
      end
      if (k == 4) begin
        n_chk++;
        if (a_stall_oh !== 4'b1000 || a_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL div_stall: oh=%b expected 1000", a_stall_oh);
        end
      end
      exp = 4'b0000;
      if (done_q.size() > 0 && done_q[0].due == cyc) exp = done_q.pop_front().oh;
      n_chk++;
      if (a_done_oh !== exp || a_done !== (|exp)) begin
        n_fail++;
        $display("FAIL div_done c%0d: oh=%b expected %b", k, a_done_oh, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    for (int k = 8; k < 19; k++) begin
      idle_in();
      if (k == 8) begin
        dt     = 2'd3;
        d_fdiv = 1'b1;
        done_q.push_back('{cyc + 8, 4'b1000});
      end
      #1;
      if (k == 8) begin
        n_chk++;
        if (a_stall !== 1'b0 || a_stall_oh !== 4'b0000) begin
          n_fail++;
          $display("FAIL b2b_nostall: stall=%b expected 0", a_stall);
        end
      end
      if (k >= 9 && k <= 16) begin
        n_chk++;
        if (a_busy !== 1'b1 || a_div_t !== 2'd3) begin
          n_fail++;
          $display("FAIL b2b_busy c%0d: busy=%b t=%0d expected 1/3", k, a_busy, a_div_t);
        end
      end
      if (k >= 17) begin
        n_chk++;
        if (a_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle c%0d: busy=%b expected 0", k, a_busy);
        end
      end
      exp = 4'b0000;
      if (done_q.size() > 0 && done_q[0].due == cyc) exp = done_q.pop_front().oh;
      n_chk++;
      if (a_done_oh !== exp || a_done !== (|exp)) begin
        n_fail++;
        $display("FAIL b2b_done c%0d: oh=%b expected %b", k, a_done_oh, exp);
      end
      tick();
    end
  endtask

  task automatic test_bad_tag();
    for (int k = 0; k < 7; k++) begin
      idle_in();
      if (k == 0) begin
        dt    = 2'd3;
        d_fwe = 1'b1;
      end
      if (k == 1 || k == 2) begin
        dt     = 2'd3;
        d_fwe  = (k == 2);
        d_fdiv = 1'b1;
      end
      #1;
      n_chk++;
      if ({b_e1w, b_e2w, b_e3w, b_ww, b_ww_oh, b_e1w_oh,
           b_stall, b_stall_oh, b_busy, b_done} !== '0) begin
        n_fail++;
        $display("FAIL bad_tag c%0d: e1w=%b ww=%b stall=%b busy=%b expected 0",
          k, b_e1w, b_ww, b_stall, b_busy);
      end
      tick();
    end
  endtask

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_pipe();
    test_interleave();
    test_div();
    test_back_to_back();
    test_bad_tag();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached expected completion");
    $fatal(1, "watchdog");
  end

endmodule
